// File: rtl/toggle_rx.sv
// toggle_rx: receiver for an enable-gated toggle line. Every level change on
// tgl_in is one event. Detected events accumulate in a saturating pending
// counter that a ready/valid consumer drains one event per cycle. An event
// that arrives while the counter is already full sets a sticky overflow flag.
//
// Build option: define TOGGLE_RX_SYNC_EN to pass tgl_in through a 2-flop
// synchronizer. Use this when the sender runs in another clock domain; it adds
// two cycles of latency. Leave the macro undefined when the sender shares
// this clock; tgl_in is then used directly.
module toggle_rx #(
   parameter int PEND_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tgl_in,
   input  logic              evt_ready,
   input  logic              ovf_clr,
   output logic              evt_valid,
   output logic [PEND_W-1:0] pend_cnt,
   output logic              ovf
);

   localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};
   localparam logic [PEND_W-1:0] CNT_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

   logic              tgl_s;
   logic              tgl_ref_q, tgl_ref_d;
   logic [PEND_W-1:0] pend_cnt_q, pend_cnt_d;
   logic              ovf_q, ovf_d;
   logic              detect;
   logic              consume;
   logic              ovf_set;

`ifdef TOGGLE_RX_SYNC_EN
   logic [1:0] sync_q;

   // Two-flop synchronizer; sync_q[1] is the metastability-safe sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], tgl_in};
      end
   end

   assign tgl_s = sync_q[1];
`else
   assign tgl_s = tgl_in;
`endif

   assign evt_valid = (pend_cnt_q != '0);
   assign detect    = (tgl_s != tgl_ref_q);
   assign consume   = evt_valid && evt_ready;

   // Next-state logic for the reference level, the pending counter and the overflow flag.
   // If a detect and a consume happen together they cancel, so a full counter
   // loses nothing in that cycle. Overflow is raised only when a detect has no
   // slot left.
   always_comb begin
      tgl_ref_d  = tgl_s;
      pend_cnt_d = pend_cnt_q;
      ovf_set    = 1'b0;
      ovf_d      = ovf_q;

      if (detect && !consume) begin
         if (pend_cnt_q == CNT_MAX) begin
            ovf_set = 1'b1;
         end else begin
            pend_cnt_d = pend_cnt_q + CNT_ONE;
         end
      end else if (consume && !detect) begin
         pend_cnt_d = pend_cnt_q - CNT_ONE;
      end

      // A fresh overflow takes priority over a clear in the same cycle.
      if (ovf_set) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   // State registers; reset discards every pending event and the reference level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tgl_ref_q  <= 1'b0;
         pend_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         tgl_ref_q  <= tgl_ref_d;
         pend_cnt_q <= pend_cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   assign pend_cnt = pend_cnt_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_toggle_rx.sv
// Bench for toggle_rx: directed scenarios with literal expectations plus a
// randomized phase, all checked against an event-counting reference model.
module tb_toggle_rx;

   localparam int PEND_W = 4;
   localparam int MAXV   = (1 << PEND_W) - 1;
`ifdef TOGGLE_RX_SYNC_EN
   localparam int SYNC_D = 2;
`else
   localparam int SYNC_D = 0;
`endif
   // Number of edges after an input change is driven before the event shows up.
   localparam int LAT = SYNC_D + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              tgl_in = 1'b0;
   logic              evt_ready = 1'b0;
   logic              ovf_clr = 1'b0;
   logic              evt_valid;
   logic [PEND_W-1:0] pend_cnt;
   logic              ovf;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   // Reference model state.
   int   m_cnt = 0;
   bit   m_ovf = 1'b0;
   bit   m_ref = 1'b0;
   bit   hist[$];

   toggle_rx #(.PEND_W(PEND_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .tgl_in    (tgl_in),
      .evt_ready (evt_ready),
      .ovf_clr   (ovf_clr),
      .evt_valid (evt_valid),
      .pend_cnt  (pend_cnt),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model. The receiver sees tgl_in delayed by SYNC_D edges (zero
   // before anything was sampled). A level different from the last accepted
   // level is one event. The pending count moves by (event - consume), except
   // that a lone event at the maximum count is lost and sets overflow.
   always @(posedge clk or posedge rst) begin : model
      bit lvl, det, con, set;
      if (rst) begin
         m_cnt = 0;
         m_ovf = 1'b0;
         m_ref = 1'b0;
         hist.delete();
      end else begin
         hist.push_front(tgl_in);
         lvl = (hist.size() > SYNC_D) ? hist[SYNC_D] : 1'b0;
         while (hist.size() > SYNC_D + 1) void'(hist.pop_back());
         det   = (lvl != m_ref);
         m_ref = lvl;
         con   = (m_cnt != 0) && evt_ready;
         set   = det && !con && (m_cnt == MAXV);
         if (!set) m_cnt = m_cnt + int'(det) - int'(con);
         if (set) m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
      end
   end

   // Compare the DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_pend_cnt", int'(pend_cnt), m_cnt);
         chk("model_evt_valid", int'(evt_valid), int'(m_cnt != 0));
         chk("model_ovf", int'(ovf), int'(m_ovf));
      end
   end

   task automatic do_reset();
      rst    = 1'b1;
      tgl_in = 1'b0;
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      int since;
      do_reset();
      cmp_en = 1'b1;
      chk("reset_pend_cnt", int'(pend_cnt), 0);
      chk("reset_evt_valid", int'(evt_valid), 0);
      chk("reset_ovf", int'(ovf), 0);

      // First event followed by a one-cycle consume.
      tgl_in = 1'b1;
      tick(LAT);
      chk("first_evt_pend", int'(pend_cnt), 1);
      chk("first_evt_valid", int'(evt_valid), 1);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      chk("consume_pend", int'(pend_cnt), 0);
      chk("consume_valid", int'(evt_valid), 0);

      // Fill the counter to saturation, then one more toggle.
      for (int i = 0; i < MAXV; i++) begin
         tgl_in = ~tgl_in;
         tick(3);
      end
      chk("fill_pend", int'(pend_cnt), MAXV);
      chk("fill_ovf", int'(ovf), 0);
      tgl_in = ~tgl_in;
      tick(3);
      chk("sat_pend", int'(pend_cnt), MAXV);
      chk("sat_ovf", int'(ovf), 1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("ovf_clr", int'(ovf), 0);

      // Event at full count in the same edge as a consume.
      tgl_in = ~tgl_in;
      tick(LAT - 1);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      chk("full_det_con_pend", int'(pend_cnt), MAXV);
      chk("full_det_con_ovf", int'(ovf), 0);

      // Saturating event in the same edge as ovf_clr: overflow wins.
      tgl_in = ~tgl_in;
      tick(LAT - 1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("ovf_vs_clr", int'(ovf), 1);
      chk("ovf_vs_clr_pend", int'(pend_cnt), MAXV);

      // Mid-cycle reset with tgl_in high, then exactly one event after release.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tgl_in = ~tgl_in;
         tick(3);
      end
      chk("pre_rst_pend", int'(pend_cnt), 3);
      tick(1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_pend", int'(pend_cnt), 0);
      chk("async_rst_valid", int'(evt_valid), 0);
      chk("async_rst_ovf", int'(ovf), 0);
      tick(2);
      rst = 1'b0;
      tick(LAT);
      chk("post_rst_pend", int'(pend_cnt), 1);
      tick(4);
      chk("post_rst_hold", int'(pend_cnt), 1);

      // Back-to-back toggles while the consumer is always ready.
      do_reset();
      evt_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tgl_in = ~tgl_in;
         tick(1);
`ifndef TOGGLE_RX_SYNC_EN
         chk("b2b_pend", int'(pend_cnt), 1);
`endif
      end
      tick(LAT);
      chk("b2b_drain", int'(pend_cnt), 0);
      evt_ready = 1'b0;

      // Randomized phase: bursts with a slow consumer reach saturation.
      since = 3;
      for (int c = 0; c < 3000; c++) begin
         if (since >= 3 && $urandom_range(0, 2) == 0) begin
            tgl_in = ~tgl_in;
            since = 0;
         end else begin
            since++;
         end
         evt_ready = ((c / 400) % 2 == 0) ? ($urandom_range(0, 9) == 0)
                                          : ($urandom_range(0, 1) == 1);
         ovf_clr   = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 700) == 0) begin
            rst = 1'b1;
            tgl_in = 1'b0;
            tick(1);
            rst = 1'b0;
            since = 3;
         end else begin
            tick(1);
         end
      end
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
      tick(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/toggle_rx.md
TOGGLE_RX -- requirements
Module: toggle_rx

Interface
REQ-001 Parameter: PEND_W, default 4, width of the pending-event counter (legal 2..8).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: tgl_in  input  1  toggle line from an enable-gated toggle sender; each level change = one event.
REQ-005 Port: evt_ready  input  1  consumer ready; one event consumed per cycle when evt_valid && evt_ready.
REQ-006 Port: ovf_clr  input  1  synchronous clear of the sticky overflow flag.
REQ-007 Port: evt_valid  output  1  high when at least one event is pending.
REQ-008 Port: pend_cnt  output  PEND_W  number of detected, unconsumed events.
REQ-009 Port: ovf  output  1  sticky flag; an event was lost because pend_cnt was saturated.

Function
REQ-010 The block SHALL hold a reference register tgl_ref holding the last accepted toggle level.
REQ-011 An event SHALL be detected in a cycle when the sampled toggle level (tgl_s) differs from tgl_ref; on that edge tgl_ref <= tgl_s.
REQ-012 At most one event SHALL be detected per cycle; the sender guarantees that consecutive toggles are at least 1 cycle apart (3 cycles with the synchronizer).
REQ-013 evt_valid SHALL equal (pend_cnt != 0), combinationally from the register.
REQ-014 Consume = evt_valid && evt_ready; evt_ready while evt_valid is low SHALL have no effect.
REQ-015 Detect only: pend_cnt +1; consume only: pend_cnt -1; detect and consume together: pend_cnt unchanged.
REQ-016 Detect with pend_cnt = 2^PEND_W-1 and no consume: pend_cnt SHALL hold (saturate) and ovf SHALL set on that edge.
REQ-017 Detect with pend_cnt at maximum and a simultaneous consume: pend_cnt unchanged and ovf not set.
REQ-018 pend_cnt SHALL never wrap: not above maximum, not below 0.
REQ-019 ovf_clr SHALL clear ovf on the next edge; a new overflow in the same cycle as ovf_clr SHALL win (ovf stays 1).
REQ-020 Latency with the synchronizer: a tgl_in change set up before edge E0 SHALL appear as pend_cnt/evt_valid after edge E2.

Reset
REQ-021 While rst is high: synchronizer flops = 0, tgl_ref = 0, pend_cnt = 0, evt_valid = 0, ovf = 0, asynchronously.
REQ-022 Reset mid-operation SHALL discard all pending events and any in-flight synchronizer state.
REQ-023 tgl_in = 1 at reset release SHALL be counted as exactly one event; the sender resets its toggle to 0 under the same reset.

Configuration
REQ-024 Macro TOGGLE_RX_SYNC_EN defined: tgl_s = output of a 2-flop synchronizer on tgl_in; latency per REQ-020; for sources in other clock domains.
REQ-025 TOGGLE_RX_SYNC_EN undefined: tgl_s = tgl_in directly (same-clock source); a change set up before E0 SHALL appear after edge E0; ports unchanged.

Verification
REQ-026 Reset, tgl_in 0->1 (sync on) before E0 -> evt_valid=1, pend_cnt=1 after E2; evt_ready=1 one cycle -> pend_cnt=0, evt_valid=0.
REQ-027 evt_ready=0, 15 toggles spaced 3 cycles (PEND_W=4) -> pend_cnt=15, ovf=0; 16th toggle -> pend_cnt=15, ovf=1; ovf_clr pulse -> ovf=0.
REQ-028 pend_cnt=15, event detected in the same cycle as evt_ready=1 -> pend_cnt=15, ovf stays 0.
REQ-029 pend_cnt=3, rst pulsed mid-cycle with tgl_in=1 -> outputs 0 immediately; after release one event counted -> pend_cnt=1.
REQ-030 Sync off: toggle every cycle for 5 cycles, evt_ready=1 -> pend_cnt stays 1 while toggling, returns to 0 one cycle after the last toggle; no event lost.
REQ-031 ovf_clr asserted in the same cycle as a saturating detect -> ovf=1 after the edge.
